// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle sequencer for long-ALU ops (MULT/MULTU/DIV/DIVU and
// their doubleword forms). It runs an iterative shift-add multiply or restoring
// divide on operand magnitudes, fixes the sign at the end, and owns HI/LO.
//
// Ports
//   clk        core clock
//   rst        synchronous active-high reset
//   start      EX holds a valid long-ALU op this cycle
//   op_div     1 = divide, 0 = multiply
//   op_signed  signed op
//   op_dword   1 = 64-bit op, 0 = 32-bit op on rs[31:0]/rt[31:0]
//   rs, rt     operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   rd_hilo    MFHI/MFLO in EX this cycle
//   wr_hi      MTHI write request
//   wr_lo      MTLO write request
//   wdata      MTHI/MTLO data
//   kill       flush of the in-flight op
//   busy       op in flight
//   done       one-cycle pulse, HI/LO take the result at the end of this cycle
//   stall      busy & (start | rd_hilo | wr_hi | wr_lo)
//   hi, lo     HI/LO registers
//
// Build option: MULDIV_FASTMUL_EN defined -> multiply retires 2 bits/cycle
// (radix-4 with a precomputed 3A); divide always retires 1 bit/cycle.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO accepted here only
// PREP  | take magnitudes, record result signs, load iteration counter
// ITER  | one (or two, fast multiply) result bits per cycle
// FIX   | sign fix, HI/LO written at end of cycle, done asserted
module muldiv_seq #(
  parameter int W  = 64,
  parameter int CW = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op_div,
  input  logic         op_signed,
  input  logic         op_dword,
  input  logic [W-1:0] rs,
  input  logic [W-1:0] rt,
  input  logic         rd_hilo,
  input  logic         wr_hi,
  input  logic         wr_lo,
  input  logic [W-1:0] wdata,
  input  logic         kill,
  output logic         busy,
  output logic         done,
  output logic         stall,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t          state, nstate;
  logic [CW-1:0]   cnt, cnt_load;
  logic            div_r, sgn_r, dw_r;
  logic [W-1:0]    a_raw, b_raw, a_mag, b_mag;
  logic [W+2:0]    acc_hi, acc_hi_n;   // multiply partial product / divide remainder
  logic [W-1:0]    acc_lo, acc_lo_n;   // multiplier bits / dividend-then-quotient
  logic            neg_lo, neg_hi, div0;
  logic            sa, sb;
  logic [W-1:0]    mag_a, mag_b;
  logic [W:0]      rem_sh;
  logic            rem_ge;
  logic [W+2:0]    addend, sum;
`ifdef MULDIV_FASTMUL_EN
  logic [W+1:0]    a3;
`endif
  logic [2*W-1:0]  p_raw, p_fix;
  logic [W-1:0]    q_fix, r_fix, res_hi, res_lo;

  function automatic logic [W-1:0] sext32(input logic [31:0] v);
    return {{(W-32){v[31]}}, v};
  endfunction

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic dw,
                                             input logic neg);
    logic [31:0] t32;
    t32 = neg ? (~v[31:0] + 32'd1) : v[31:0];
    if (dw) return neg ? (~v + 1'b1) : v;
    return {{(W-32){1'b0}}, t32};
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // next state
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = PREP;
      PREP:    nstate = ITER;
      ITER:    if (cnt == CW'(1)) nstate = FIX;
      FIX:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
    if (kill) nstate = IDLE;
  end

  // outputs
  always_comb begin
    busy  = (state != IDLE);
    done  = (state == FIX) && !kill;
    stall = busy && (start || rd_hilo || wr_hi || wr_lo);
  end

  // operand preparation
  always_comb begin
    sa       = sgn_r && (dw_r ? a_raw[W-1] : a_raw[31]);
    sb       = sgn_r && (dw_r ? b_raw[W-1] : b_raw[31]);
    mag_a    = magnitude(a_raw, dw_r, sa);
    mag_b    = magnitude(b_raw, dw_r, sb);
    cnt_load = dw_r ? CW'(W) : CW'(W/2);
`ifdef MULDIV_FASTMUL_EN
    if (!div_r) cnt_load = cnt_load >> 1;
`endif
  end

  // one iteration step
  always_comb begin
    rem_sh   = {acc_hi[W-1:0], acc_lo[W-1]};
    rem_ge   = (rem_sh >= {1'b0, b_mag});
    addend   = '0;
    sum      = '0;
    acc_hi_n = acc_hi;
    acc_lo_n = acc_lo;
`ifdef MULDIV_FASTMUL_EN
    a3       = {1'b0, a_mag, 1'b0} + {2'b0, a_mag};
`endif
    if (div_r) begin
      acc_hi_n = {2'b0, (rem_ge ? (rem_sh - {1'b0, b_mag}) : rem_sh)};
      acc_lo_n = {acc_lo[W-2:0], rem_ge};
    end else begin
`ifdef MULDIV_FASTMUL_EN
      case (acc_lo[1:0])
        2'd1:    addend = {3'b0, a_mag};
        2'd2:    addend = {2'b0, a_mag, 1'b0};
        2'd3:    addend = {1'b0, a3};
        default: addend = '0;
      endcase
      sum      = acc_hi + addend;
      acc_hi_n = {2'b0, sum[W+2:2]};
      acc_lo_n = {sum[1:0], acc_lo[W-1:2]};
`else
      addend   = acc_lo[0] ? {3'b0, a_mag} : '0;
      sum      = acc_hi + addend;
      acc_hi_n = {1'b0, sum[W+2:1]};
      acc_lo_n = {sum[0], acc_lo[W-1:1]};
`endif
    end
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          div_r <= op_div;
          sgn_r <= op_signed;
          dw_r  <= op_dword;
          a_raw <= rs;
          b_raw <= rt;
        end
        PREP: begin
          a_mag  <= mag_a;
          b_mag  <= mag_b;
          neg_lo <= sa ^ sb;
          neg_hi <= div_r ? sa : (sa ^ sb);
          div0   <= (mag_b == '0);
          acc_hi <= '0;
          // 32-bit dividends are left-aligned so the quotient lands in acc_lo[31:0]
          acc_lo <= !div_r ? mag_b :
                    dw_r   ? mag_a : {mag_a[31:0], {(W-32){1'b0}}};
          cnt    <= cnt_load;
        end
        ITER: begin
          acc_hi <= acc_hi_n;
          acc_lo <= acc_lo_n;
          cnt    <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // result formatting; a 32-bit product sits at acc bit 32 after its 32 shifts
  always_comb begin
    p_raw = dw_r ? {acc_hi[W-1:0], acc_lo}
                 : {{W{1'b0}}, acc_hi[31:0], acc_lo[W-1:32]};
    p_fix = neg_lo ? (~p_raw + 1'b1) : p_raw;
    q_fix = neg_lo ? (~acc_lo + 1'b1) : acc_lo;
    r_fix = neg_hi ? (~acc_hi[W-1:0] + 1'b1) : acc_hi[W-1:0];
    if (!div_r) begin
      res_lo = dw_r ? p_fix[W-1:0]   : sext32(p_fix[31:0]);
      res_hi = dw_r ? p_fix[2*W-1:W] : sext32(p_fix[63:32]);
    end else if (div0) begin
      res_lo = '1;
      res_hi = dw_r ? a_raw : sext32(a_raw[31:0]);
    end else begin
      res_lo = dw_r ? q_fix : sext32(q_fix[31:0]);
      res_hi = dw_r ? r_fix : sext32(r_fix[31:0]);
    end
  end

  // HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX && !kill) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (state == IDLE) begin
      if (wr_hi) hi <= wdata;
      if (wr_lo) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

  logic        clk, rst, start, op_div, op_signed, op_dword;
  logic [63:0] rs, rt, wdata;
  logic        rd_hilo, wr_hi, wr_lo, kill;
  logic        busy, done, stall;
  logic [63:0] hi, lo;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    string       nm;
    logic        d, s, dw;
    logic [63:0] a, b, eh, el;
  } vec_t;

  typedef struct {
    string       nm;
    logic [63:0] hi, lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  vec_t vecs[$];

  muldiv_seq #(.W(64), .CW(7)) dut (
    .clk(clk), .rst(rst), .start(start), .op_div(op_div), .op_signed(op_signed),
    .op_dword(op_dword), .rs(rs), .rt(rt), .rd_hilo(rd_hilo), .wr_hi(wr_hi),
    .wr_lo(wr_lo), .wdata(wdata), .kill(kill), .busy(busy), .done(done),
    .stall(stall), .hi(hi), .lo(lo)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy === 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) chk("idle_wait", 64'(busy), 64'd0);
  endtask

  task automatic issue(input string nm, input logic d, input logic s, input logic dw,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] eh, input logic [63:0] el, input bit push);
    int n, lat;
    exp_t x;
    wait_idle();
    n = dw ? 64 : 32;
`ifdef MULDIV_FASTMUL_EN
    lat = d ? n + 2 : n / 2 + 2;
`else
    lat = n + 2;
`endif
    start = 1; op_div = d; op_signed = s; op_dword = dw; rs = a; rt = b;
    if (push) begin
      x.nm = nm; x.hi = eh; x.lo = el; x.cyc = cyc + lat;
      sb.push_back(x);
    end
    @(negedge clk);
    start = 0;
  endtask

  task automatic mt(input logic h, input logic l, input logic [63:0] data);
    wr_hi = h; wr_lo = l; wdata = data;
    @(negedge clk);
    wr_hi = 0; wr_lo = 0;
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (done === 1'b1) begin
        chk("done_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk({e.nm, " latency"}, 64'(cyc), 64'(e.cyc));
          @(posedge clk);
          #1;
          chk({e.nm, " hi"}, hi, e.hi);
          chk({e.nm, " lo"}, lo, e.lo);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    vecs.push_back('{"mult_neg1x2",   0, 1, 0, 64'hFFFFFFFF, 64'd2,
                     64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE});
    vecs.push_back('{"multu_ffx2",    0, 0, 0, 64'hFFFFFFFF, 64'd2,
                     64'h1, 64'hFFFFFFFFFFFFFFFE});
    vecs.push_back('{"dmultu_2p63x4", 0, 0, 1, 64'h8000000000000000, 64'd4,
                     64'h2, 64'h0});
    vecs.push_back('{"div_m7_2",      1, 1, 0, 64'hFFFFFFFFFFFFFFF9, 64'd2,
                     64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFD});
    vecs.push_back('{"ddivu_5_0",     1, 0, 1, 64'd5, 64'd0,
                     64'h5, 64'hFFFFFFFFFFFFFFFF});
    vecs.push_back('{"div_ovf",       1, 1, 0, 64'h80000000, 64'hFFFFFFFF,
                     64'h0, 64'hFFFFFFFF80000000});
    vecs.push_back('{"dmult_m3x5",    0, 1, 1, 64'hFFFFFFFFFFFFFFFD, 64'd5,
                     64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF1});
    vecs.push_back('{"ddiv_m100_7",   1, 1, 1, 64'hFFFFFFFFFFFFFF9C, 64'd7,
                     64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFF2});
    vecs.push_back('{"divu_ff_16",    1, 0, 0, 64'hFFFFFFFF, 64'h10,
                     64'hF, 64'h0FFFFFFF});
    vecs.push_back('{"dmultu_max",    0, 0, 1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                     64'hFFFFFFFFFFFFFFFE, 64'h1});
    vecs.push_back('{"mult_minsq",    0, 1, 0, 64'h80000000, 64'h80000000,
                     64'h40000000, 64'h0});
    vecs.push_back('{"div_s_by0",     1, 1, 0, 64'hFFFFFFF0, 64'd0,
                     64'hFFFFFFFFFFFFFFF0, 64'hFFFFFFFFFFFFFFFF});
    vecs.push_back('{"divu_trunc",    1, 0, 0, 64'h1234567800000064, 64'hABCD000000000007,
                     64'h2, 64'hE});
    vecs.push_back('{"ddivu_big",     1, 0, 1, 64'hFFFFFFFFFFFFFFFF, 64'h100000000,
                     64'hFFFFFFFF, 64'hFFFFFFFF});
    vecs.push_back('{"multu_bit31",   0, 0, 0, 64'h10000, 64'h8000,
                     64'h0, 64'hFFFFFFFF80000000});

    rst = 1; start = 0; op_div = 0; op_signed = 0; op_dword = 0; rs = 0; rt = 0;
    rd_hilo = 0; wr_hi = 0; wr_lo = 0; wdata = 0; kill = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("reset busy",  64'(busy),  64'd0);
    chk("reset done",  64'(done),  64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    chk("reset hi", hi, 64'd0);
    chk("reset lo", lo, 64'd0);
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i].nm, vecs[i].d, vecs[i].s, vecs[i].dw, vecs[i].a, vecs[i].b,
            vecs[i].eh, vecs[i].el, 1'b1);
      wait_idle();
    end

    // MTHI while busy is suppressed and stalls
    mt(1, 1, 64'h77);
    #1;
    chk("mt hi", hi, 64'h77);
    chk("mt lo", lo, 64'h77);
    issue("multu_3x5", 0, 0, 0, 64'd3, 64'd5, 64'd0, 64'd15, 1'b1);
    @(negedge clk);
    wr_hi = 1; wdata = 64'hDEAD;
    #1;
    chk("mthi busy stall", 64'(stall), 64'd1);
    @(negedge clk);
    wr_hi = 0;
    #1;
    chk("mthi busy suppressed", hi, 64'h77);
    wait_idle();

    // MFLO from T+5 of a DIV stalls until the cycle after done
    @(negedge clk);
    issue("div_100_7", 1, 1, 0, 64'd100, 64'd7, 64'd2, 64'd14, 1'b1);
    repeat (4) @(negedge clk);
    rd_hilo = 1;
    for (int i = 5; i <= 35; i++) begin
      #1;
      chk($sformatf("mflo stall T+%0d", i), 64'(stall), 64'(i <= 34));
      if (i == 35) chk("mflo lo after stall", lo, 64'd14);
      if (i < 35) @(negedge clk);
    end
    rd_hilo = 0;
    @(negedge clk);

    // kill mid-op
    mt(1, 1, 64'h1234);
    issue("dmult_killed", 0, 1, 1, 64'd3, 64'd4, 64'd0, 64'd0, 1'b0);
    repeat (9) @(negedge clk);
    kill = 1;
    @(negedge clk);
    kill = 0;
    #1;
    chk("kill busy", 64'(busy), 64'd0);
    repeat (80) @(negedge clk);
    chk("kill hi kept", hi, 64'h1234);
    chk("kill lo kept", lo, 64'h1234);
    mt(0, 1, 64'h55);
    #1;
    chk("mtlo after kill", lo, 64'h55);
    chk("hi after mtlo", hi, 64'h1234);

    // kill with start in IDLE drops the op
    @(negedge clk);
    start = 1; kill = 1; op_div = 0; op_dword = 1; rs = 64'd9; rt = 64'd9;
    @(negedge clk);
    start = 0; kill = 0;
    #1;
    chk("kill start dropped", 64'(busy), 64'd0);

    // reset mid-op
    @(negedge clk);
    issue("ddiv_reset", 1, 1, 1, 64'd1000, 64'd3, 64'd0, 64'd0, 1'b0);
    repeat (19) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst mid busy", 64'(busy), 64'd0);
    chk("rst mid hi", hi, 64'd0);
    chk("rst mid lo", lo, 64'd0);
    @(negedge clk);
    issue("mult_after_rst", 0, 1, 0, 64'h7FFFFFFF, 64'hFFFFFFFF,
          64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000001, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
